openhw_skid_buffer: RTL
=======================

OPENHW_SKID_BUFFER -- requirements
Module: openhw_skid_buffer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the payload width in bits (legal range 1..1024).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port flush, input, 1 bit: synchronous discard of all buffered entries.
REQ-005 The block SHALL have port in_valid, input, 1 bit: upstream offers in_data.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept (registered).
REQ-007 The block SHALL have port in_data, input, WIDTH bits: upstream payload.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_data holds a valid entry (registered).
REQ-009 The block SHALL have port out_ready, input, 1 bit: downstream accepts.
REQ-010 The block SHALL have port out_data, output, WIDTH bits: payload, driven directly from the main register.

Function
REQ-011 The block SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready; a transfer occurs only on a fire.
REQ-012 The block SHALL hold two WIDTH-bit registers, main and skid, and a state register with states EMPTY (0 entries), BUSY (main only) and FULL (main and skid).
REQ-013 In EMPTY, in_fire SHALL load main from in_data and move to BUSY; otherwise the block SHALL stay in EMPTY.
REQ-014 In BUSY, the block SHALL behave as follows:
- in_fire & out_fire: load main from in_data, stay in BUSY.
- in_fire only: load skid from in_data, go to FULL.
- out_fire only: go to EMPTY.
- neither: hold.
REQ-015 In FULL, out_fire SHALL copy skid into main and go to BUSY; otherwise the block SHALL hold; in_fire cannot occur in FULL.
REQ-016 in_ready SHALL be a flop output equal to 1 exactly when the next state is not FULL, so it never depends combinationally on out_ready.
REQ-017 out_valid SHALL equal 1 exactly when the state is BUSY or FULL.
REQ-018 Latency from in_fire to out_valid with an empty buffer SHALL be 1 cycle; sustained throughput SHALL be 1 transfer per cycle.
REQ-019 out_data SHALL remain stable while out_valid & !out_ready.
REQ-020 Entries SHALL leave in strict arrival order; none SHALL be dropped or duplicated.
REQ-021 flush SHALL take priority over all fires in the same cycle:
- next state = EMPTY, out_valid = 0, in_ready = 1;
- an in_fire in the same cycle is discarded.
REQ-022 The main and skid registers SHALL load only on the fires listed above; their contents when out_valid = 0 are don't-care.

Reset
REQ-023 While reset_n = 0, the block SHALL drive: state = EMPTY, out_valid = 0, in_ready = 0, main = 0, skid = 0, asynchronously.
REQ-024 in_ready SHALL rise at the first rising clk edge after reset_n deasserts.
REQ-025 A reset mid-transfer SHALL discard all buffered entries with no partial output.

Structure
REQ-026 Package openhw_skid_pkg SHALL contain typedef skid_state_t (2-bit enum EMPTY=2'b00, BUSY=2'b01, FULL=2'b10).
REQ-027 The main and skid registers SHALL each be an instance of sub-module openhw_flopenr_n: an enabled D flop with asynchronous active-low reset to 0, parameterised by WIDTH.
REQ-028 The state register and in_ready flop SHALL live in openhw_skid_buffer; no other sub-modules SHALL be used.

Verification
REQ-029 The bench SHALL cover reset release: reset_n low then high, in_valid=1 with data 0x11 -> in_ready=0 before the first edge, 1 after it; out_valid=1 with 0x11 one cycle after acceptance.
REQ-030 The bench SHALL cover streaming: out_ready=1, in_valid=1 with data 0x01..0x10 on consecutive cycles -> out_data 0x01..0x10 on consecutive cycles, one cycle later, with no bubbles.
REQ-031 The bench SHALL cover backpressure: out_ready=0, send 0xA1 then 0xA2 -> in_ready=0 after the second accept and out_data holds 0xA1; raise out_ready -> 0xA1, then 0xA2, and in_ready returns to 1.
REQ-032 The bench SHALL cover flush while FULL: flush=1 with in_valid=1 and data 0xFF in the same cycle -> next cycle out_valid=0, in_ready=1, and 0xFF never appears at the output.
REQ-033 The bench SHALL cover asynchronous reset mid-stream: reset_n pulsed low between edges while FULL -> out_valid and in_ready drop immediately with no clock edge, and no stale data appears after release.
REQ-034 The bench SHALL run random in_valid/out_ready for 10k cycles against a scoreboard -> order preserved, no loss, out_data stable under stall, for WIDTH = 1 and WIDTH = 64.

Source files
------------

// File: rtl/openhw_skid_pkg.sv
// rtl/openhw_skid_pkg.sv - state type and next-state helper for the skid buffer
package openhw_skid_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } skid_state_t;

  // Occupancy transition; flush overrides every fire in the same cycle
  function automatic skid_state_t skid_next(
    input skid_state_t cur,
    input logic        in_fire,
    input logic        out_fire,
    input logic        flush
  );
    skid_state_t nxt;
    nxt = cur;
    if (flush) begin
      nxt = EMPTY;
    end else begin
      case (cur)
        EMPTY: if (in_fire) nxt = BUSY;
        BUSY: begin
          if (in_fire && !out_fire)      nxt = FULL;
          else if (!in_fire && out_fire) nxt = EMPTY;
        end
        FULL:    if (out_fire) nxt = BUSY;
        default: nxt = EMPTY;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/openhw_flopenr_n.sv
// rtl/openhw_flopenr_n.sv - enabled D flop with async active-low reset to zero
module openhw_flopenr_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture d only when enabled; clear immediately on reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  q <= '0;
    else if (en)   q <= d;
  end

endmodule

// File: rtl/openhw_skid_buffer.sv
// rtl/openhw_skid_buffer.sv - two-entry skid buffer with registered in_ready and out_valid
module openhw_skid_buffer
  import openhw_skid_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  skid_state_t      state_q;
  skid_state_t      state_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             in_fire;
  logic             out_fire;
  logic             main_en;
  logic             skid_en;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid_q & out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

  // Next occupancy and register load enables; flush suppresses every load
  always_comb begin
    state_d = skid_next(state_q, in_fire, out_fire, flush);
    main_en = 1'b0;
    skid_en = 1'b0;
    main_d  = in_data;
    if (!flush) begin
      case (state_q)
        EMPTY: main_en = in_fire;
        BUSY: begin
          main_en = in_fire & out_fire;
          skid_en = in_fire & ~out_fire;
        end
        FULL: begin
          main_en = out_fire;
          main_d  = skid_q;
        end
        default: ;
      endcase
    end
  end

  // State plus registered handshake outputs, all derived from the next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
    end
  end

  openhw_flopenr_n #(.WIDTH(WIDTH)) u_main (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (main_en),
    .d       (main_d),
    .q       (main_q)
  );

  openhw_flopenr_n #(.WIDTH(WIDTH)) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (skid_en),
    .d       (in_data),
    .q       (skid_q)
  );

endmodule
